reg2tl_master: RTL and testbench



---
 rtl/reg2tl_master.sv | 171 +++++++++++++++++
 tb/tb_reg2tl_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg2tl_master.sv
// Register-bus slave to TileLink-UL master bridge: one single-beat Get/Put in flight,
// one-cycle response pulse carrying read data / error, optional D-channel timeout.
package tl_pkg;
  typedef logic [7:0] source_t;

  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] GET              = 3'd4;
  localparam logic [2:0] ACCESS_ACK       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    source_t     source;
    logic [63:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    source_t     source;
    logic [7:0]  sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } D_chan_bits_t;
endpackage

module reg2tl_master #(
  parameter int unsigned     ADDR_WIDTH     = 64,
  parameter int unsigned     DATA_WIDTH     = 64,
  parameter tl_pkg::source_t SOURCE_ID      = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output logic                      TL_A_valid_o,
  input  logic                      TL_A_ready_i,
  output tl_pkg::A_chan_bits_t      TL_A_bits_o,
  input  logic                      TL_D_valid_i,
  output logic                      TL_D_ready_o,
  input  tl_pkg::D_chan_bits_t      TL_D_bits_i
);

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    late_q;
  logic [31:0]             timer_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic d_match;
  logic timeout_hit;
  logic rsp_err;
  logic unused_d_bits;

  assign d_match = TL_D_valid_i && (TL_D_bits_i.source == SOURCE_ID);

  // Fires in the D_WAIT cycle where the timer would step onto TIMEOUT_CYCLES-1.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((timer_q + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));

  assign rsp_err = TL_D_bits_i.denied | TL_D_bits_i.corrupt |
                   (we_q ? (TL_D_bits_i.opcode != tl_pkg::ACCESS_ACK)
                         : (TL_D_bits_i.opcode != tl_pkg::ACCESS_ACK_DATA));

  assign unused_d_bits = ^{TL_D_bits_i.param, TL_D_bits_i.size, TL_D_bits_i.sink};

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

  always_comb begin
    state_d      = state_q;
    gnt_o        = 1'b0;
    TL_A_valid_o = 1'b0;
    TL_D_ready_o = 1'b0;
    rvalid_o     = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o        = req_i & ~late_q & ~rst_i;
        TL_D_ready_o = late_q;
        if (gnt_o) state_d = A_SEND;
      end
      A_SEND: begin
        TL_A_valid_o = 1'b1;
        if (TL_A_ready_i) state_d = D_WAIT;
      end
      D_WAIT: begin
        TL_D_ready_o = 1'b1;
        if (d_match || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rvalid_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TL_A_bits_o = '0;
    if (state_q == A_SEND) begin
      if (!we_q)          TL_A_bits_o.opcode = tl_pkg::GET;
      else if (be_q == '1) TL_A_bits_o.opcode = tl_pkg::PUT_FULL_DATA;
      else                TL_A_bits_o.opcode = tl_pkg::PUT_PARTIAL_DATA;
      TL_A_bits_o.size    = 3'd3;
      TL_A_bits_o.source  = SOURCE_ID;
      TL_A_bits_o.address = 64'(addr_q);
      TL_A_bits_o.mask    = 8'(be_q);
      TL_A_bits_o.data    = we_q ? 64'(wdata_q) : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      late_q  <= 1'b0;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_o) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
      if (state_q == A_SEND && TL_A_ready_i) timer_q <= '0;
      // A matching beat wins over a timeout landing in the same cycle.
      if (state_q == D_WAIT) begin
        if (d_match) begin
          rdata_q <= we_q ? '0 : DATA_WIDTH'(TL_D_bits_i.data);
          err_q   <= rsp_err;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          late_q  <= 1'b1;
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end
      if (state_q == IDLE && late_q && d_match) late_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg2tl_master.sv
// Directed + randomized bench for reg2tl_master; expected timing and responses
// come from a transaction-level model (latency arithmetic per transaction).
module tb_reg2tl_master;
  localparam int unsigned     T   = 8;
  localparam tl_pkg::source_t SRC = 8'h03;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 req_i, gnt_o, we_i;
  logic [63:0]          addr_i, wdata_i, rdata_o;
  logic [7:0]           be_i;
  logic                 rvalid_o, err_o;
  logic                 TL_A_valid_o, TL_A_ready_i, TL_D_valid_i, TL_D_ready_o;
  tl_pkg::A_chan_bits_t TL_A_bits_o;
  tl_pkg::D_chan_bits_t TL_D_bits_i;

  int n_cmp  = 0;
  int n_fail = 0;

  reg2tl_master #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .SOURCE_ID(SRC), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .TL_A_valid_o(TL_A_valid_o),
    .TL_A_ready_i(TL_A_ready_i), .TL_A_bits_o(TL_A_bits_o),
    .TL_D_valid_i(TL_D_valid_i), .TL_D_ready_o(TL_D_ready_o), .TL_D_bits_i(TL_D_bits_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle_inputs();
    req_i = 1'b0;
    we_i = 1'($urandom);
    addr_i = {$urandom, $urandom};
    be_i = 8'($urandom);
    wdata_i = {$urandom, $urandom};
    TL_A_ready_i = 1'b0;
    TL_D_valid_i = 1'b0;
    TL_D_bits_i = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive_d(input tl_pkg::source_t src, input logic [2:0] op, input logic den,
                         input logic cor, input logic [63:0] dd);
    TL_D_valid_i = 1'b1;
    TL_D_bits_i.opcode = op;
    TL_D_bits_i.source = src;
    TL_D_bits_i.denied = den;
    TL_D_bits_i.corrupt = cor;
    TL_D_bits_i.data = dd;
  endtask

  // One transaction starting in an IDLE cycle. d_dly counts D_WAIT cycles before the
  // matching beat; d_dly > T-2 means no beat is sent and the timeout must fire.
  task automatic do_txn(input string tag, input logic we, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wd, input int a_dly,
                        input int d_dly, input int n_for, input logic [2:0] d_op,
                        input logic den, input logic cor, input logic [63:0] dd);
    int h, exp_rv;
    logic timed_out, exp_err;
    logic [2:0] exp_op;
    logic [63:0] exp_rd;
    h = 1 + a_dly;
    timed_out = d_dly > int'(T) - 2;
    exp_rv = h + 2 + (timed_out ? int'(T) - 2 : d_dly);
    exp_op = !we ? 3'd4 : (be == 8'hFF ? 3'd0 : 3'd1);
    if (timed_out) begin
      exp_rd = '0;
      exp_err = 1'b1;
    end else begin
      exp_rd = we ? 64'h0 : dd;
      exp_err = den | cor | (d_op != (we ? 3'd0 : 3'd1));
    end
    for (int c = 0; c <= exp_rv; c++) begin
      drive_idle_inputs();
      if (c == 0) begin
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
      end
      TL_A_ready_i = (c >= h);
      if (c > h && c <= h + n_for) drive_d(SRC ^ 8'h80, 3'd1, 1'b0, 1'b0, 64'hBAD0BAD0);
      if (!timed_out && c == h + 1 + d_dly) drive_d(SRC, d_op, den, cor, dd);
      @(negedge clk_i);
      if (c == 0) chk({tag, "_gnt"}, 64'(gnt_o), 64'd1);
      if (c == 1) chk({tag, "_gnt_off"}, 64'(gnt_o), 64'd0);
      if (c >= 1 && c <= h) begin
        chk({tag, "_a_valid"}, 64'(TL_A_valid_o), 64'd1);
        chk({tag, "_a_opcode"}, 64'(TL_A_bits_o.opcode), 64'(exp_op));
        chk({tag, "_a_addr"}, TL_A_bits_o.address, addr);
        chk({tag, "_a_mask"}, 64'(TL_A_bits_o.mask), 64'(be));
        chk({tag, "_a_data"}, TL_A_bits_o.data, we ? wd : 64'h0);
        chk({tag, "_a_misc"},
            64'({TL_A_bits_o.param, TL_A_bits_o.size, TL_A_bits_o.source, TL_A_bits_o.corrupt}),
            64'({3'd0, 3'd3, SRC, 1'b0}));
      end
      if (c == h + 1) chk({tag, "_a_valid_off"}, 64'(TL_A_valid_o), 64'd0);
      if (c > h && c < exp_rv) chk({tag, "_d_ready"}, 64'(TL_D_ready_o), 64'd1);
      chk({tag, "_rvalid"}, 64'(rvalid_o), 64'(c == exp_rv));
      if (c == exp_rv) begin
        chk({tag, "_rdata"}, rdata_o, exp_rd);
        chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
      end
      next_cycle();
    end
    drive_idle_inputs();
  endtask

  initial begin
    logic        r_we, r_den, r_cor;
    logic [7:0]  r_be;
    logic [2:0]  r_op;
    int          r_ad, r_dd;

    rst_i = 1'b1;
    drive_idle_inputs();
    req_i = 1'b1;
    #2;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_a_valid", 64'(TL_A_valid_o), 64'd0);
    chk("rst_a_bits_zero", 64'(TL_A_bits_o != '0), 64'd0);
    chk("rst_d_ready", 64'(TL_D_ready_o), 64'd0);
    repeat (2) next_cycle();
    rst_i = 1'b0;
    drive_idle_inputs();
    next_cycle();

    do_txn("rd_min", 1'b0, 64'h1000, 8'hFF, 64'h0, 0, 0, 0, 3'd1, 1'b0, 1'b0,
           64'hDEADBEEF_CAFEF00D);
    do_txn("wr_partial", 1'b1, 64'h2008, 8'h0F, 64'h11223344, 5, 1, 0, 3'd0, 1'b0, 1'b0,
           64'h5555AAAA);
    do_txn("wr_full", 1'b1, 64'h2010, 8'hFF, 64'h11223344, 5, 0, 0, 3'd0, 1'b0, 1'b0,
           64'h0);
    do_txn("rd_denied", 1'b0, 64'h3000, 8'hFF, 64'h0, 0, 0, 0, 3'd1, 1'b1, 1'b0,
           64'h1234);
    do_txn("rd_wrong_op", 1'b0, 64'h3008, 8'hFF, 64'h0, 1, 0, 0, 3'd0, 1'b0, 1'b0,
           64'h0);
    do_txn("rd_corrupt", 1'b0, 64'h3010, 8'hFF, 64'h0, 0, 2, 0, 3'd1, 1'b0, 1'b1,
           64'h77);
    do_txn("rd_foreign", 1'b0, 64'h4000, 8'hFF, 64'h0, 0, 3, 2, 3'd1, 1'b0, 1'b0,
           64'h0123456789ABCDEF);
    // Matching beat in the same cycle the timer expires: normal response, no late flag.
    do_txn("rd_edge", 1'b0, 64'h4008, 8'hFF, 64'h0, 0, int'(T) - 2, 1, 3'd1, 1'b0, 1'b0,
           64'hFEEDFACE);
    do_txn("rd_after_edge", 1'b0, 64'h4010, 8'hFF, 64'h0, 0, 0, 0, 3'd1, 1'b0, 1'b0,
           64'h42);

    do_txn("rd_timeout", 1'b0, 64'h5000, 8'hFF, 64'h0, 0, 99, 0, 3'd1, 1'b0, 1'b0, 64'h0);
    for (int c = 0; c < 6; c++) begin
      drive_idle_inputs();
      req_i = 1'b1;
      if (c == 4) drive_d(SRC ^ 8'h01, 3'd1, 1'b0, 1'b0, 64'h99);
      if (c == 5) drive_d(SRC, 3'd1, 1'b0, 1'b0, 64'h5000DA7A);
      @(negedge clk_i);
      chk("late_gnt_blocked", 64'(gnt_o), 64'd0);
      chk("late_d_ready", 64'(TL_D_ready_o), 64'd1);
      chk("late_no_rvalid", 64'(rvalid_o), 64'd0);
      next_cycle();
    end
    do_txn("rd_after_late", 1'b0, 64'h5008, 8'hFF, 64'h0, 0, 0, 0, 3'd1, 1'b0, 1'b0,
           64'hC0FFEE);

    drive_idle_inputs();
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h6000; be_i = 8'hFF;
    next_cycle();
    drive_idle_inputs();
    next_cycle();
    @(negedge clk_i);
    chk("pre_rst_a_valid", 64'(TL_A_valid_o), 64'd1);
    next_cycle();
    req_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_a_valid", 64'(TL_A_valid_o), 64'd0);
    chk("async_rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("async_rst_gnt", 64'(gnt_o), 64'd0);
    next_cycle();
    rst_i = 1'b0;
    drive_idle_inputs();
    next_cycle();
    do_txn("rd_post_rst", 1'b0, 64'h6008, 8'hFF, 64'h0, 0, 0, 0, 3'd1, 1'b0, 1'b0,
           64'hA5A5_5A5A_0F0F_F0F0);

    for (int i = 0; i < 30; i++) begin
      r_we  = 1'($urandom);
      r_be  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      r_ad  = int'($urandom_range(0, 3));
      r_dd  = int'($urandom_range(0, T - 2));
      r_den = ($urandom_range(0, 5) == 0);
      r_cor = ($urandom_range(0, 5) == 0);
      r_op  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (r_we ? 3'd0 : 3'd1);
      do_txn("rand", r_we, {$urandom, $urandom}, r_be, {$urandom, $urandom}, r_ad, r_dd,
             int'($urandom_range(0, r_dd)), r_op, r_den, r_cor, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
